// File: rtl/mem_burst_initiator_if.sv
`default_nettype none
// ===========================================================================
// Module   : mem_burst_initiator_if
// Purpose  : Command, write-data, response and memory-port bundle for the
//            burst initiator.
// Revision : 1.0 - initial release
// ===========================================================================
interface mem_burst_initiator_if #(
   parameter int unsigned LEN_BITS = 4
);
   logic                req_valid;
   logic                req_ready;
   logic [31:0]         req_addr;
   logic [1:0]          req_size;
   logic                req_we;
   logic [LEN_BITS-1:0] req_len;

   logic                wr_valid;
   logic                wr_ready;
   logic [31:0]         wr_data;

   logic                rsp_valid;
   logic [31:0]         rsp_data;
   logic                done;
   logic                err;

   logic [31:0]         mem_address;
   logic [31:0]         mem_datain;
   logic [1:0]          mem_access_size;
   logic                mem_r_w;
   logic [31:0]         mem_dataout;

   // master: the initiator itself; slave: the client plus memory around it
   modport master (
      input  req_valid, req_addr, req_size, req_we, req_len, wr_valid, wr_data, mem_dataout,
      output req_ready, wr_ready, rsp_valid, rsp_data, done, err,
             mem_address, mem_datain, mem_access_size, mem_r_w
   );

   modport slave (
      output req_valid, req_addr, req_size, req_we, req_len, wr_valid, wr_data, mem_dataout,
      input  req_ready, wr_ready, rsp_valid, rsp_data, done, err,
             mem_address, mem_datain, mem_access_size, mem_r_w
   );
endinterface
`default_nettype wire

// File: rtl/mem_burst_initiator.sv
`default_nettype none
// ===========================================================================
// Module   : mem_burst_initiator
// Purpose  : Burst read/write initiator for the big-endian 1 MB data memory,
//            one registered beat per clock, two-stage completion pipeline.
// Revision : 1.0 - initial release
// ===========================================================================
module mem_burst_initiator #(
   parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
   parameter int unsigned MEM_BYTES = 1048576,
   parameter int unsigned LEN_BITS  = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   mem_burst_initiator_if.master bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REJECT = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   localparam logic [32:0] c_window_end = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         2'b11:   return 3'd4;
         2'b10:   return 3'd2;
         default: return 3'd1;
      endcase
   endfunction

   state_t              r_state, w_state_next;
   logic [31:0]         r_addr;
   logic [1:0]          r_size;
   logic                r_we;
   logic [LEN_BITS-1:0] r_beats_left;
   logic                r_p1_valid, r_p1_read, r_p1_last;
   logic                r_p2_valid, r_p2_read, r_p2_last;
   logic [31:0]         r_mem_address, r_mem_datain;
   logic [1:0]          r_mem_access_size;
   logic                r_mem_r_w;
   logic                r_rsp_valid, r_done, r_err;
   logic [31:0]         r_rsp_data;

   logic                w_req_ready, w_wr_ready, w_accept;
   logic [2:0]          w_req_bytes;
   logic [32:0]         w_req_end;
   logic                w_misaligned, w_out_of_range, w_reject;
   logic                w_issue_read, w_issue_write, w_issue, w_last_beat;

   // Address bit numbering on the bus is big-endian; [1:0] here are its bits 30:31.
   assign w_req_bytes    = size_bytes(bus.req_size);
   assign w_misaligned   = ((bus.req_size == 2'b11) && (bus.req_addr[1:0] != 2'b00)) ||
                           ((bus.req_size == 2'b10) && bus.req_addr[0]);
   assign w_req_end      = {1'b0, bus.req_addr} +
                           (33'(bus.req_len) + 33'd1) * 33'(w_req_bytes);
   assign w_out_of_range = (bus.req_addr < BASE_ADDR) || (w_req_end > c_window_end);
   assign w_reject       = w_misaligned || w_out_of_range;
   assign w_accept       = (r_state == IDLE) && bus.req_valid;

   assign w_issue_read   = (r_state == RUN) && !r_we;
   assign w_issue_write  = (r_state == RUN) && r_we && bus.wr_valid;
   assign w_issue        = w_issue_read || w_issue_write;
   assign w_last_beat    = (r_beats_left == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_req_ready  = 1'b0;
      w_wr_ready   = 1'b0;
      case (r_state)
         IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) w_state_next = w_reject ? REJECT : RUN;
         end
         REJECT: w_state_next = IDLE;
         RUN: begin
            w_wr_ready = r_we;
            if (w_issue && w_last_beat) w_state_next = DRAIN;
         end
         DRAIN: if (r_p2_valid && r_p2_last) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_addr            <= BASE_ADDR;
         r_size            <= 2'b11;
         r_we              <= 1'b0;
         r_beats_left      <= '0;
         r_p1_valid        <= 1'b0;
         r_p1_read         <= 1'b0;
         r_p1_last         <= 1'b0;
         r_p2_valid        <= 1'b0;
         r_p2_read         <= 1'b0;
         r_p2_last         <= 1'b0;
         r_mem_address     <= BASE_ADDR;
         r_mem_datain      <= 32'h0;
         r_mem_access_size <= 2'b11;
         r_mem_r_w         <= 1'b0;
         r_rsp_valid       <= 1'b0;
         r_rsp_data        <= 32'h0;
         r_done            <= 1'b0;
         r_err             <= 1'b0;
      end else begin
         // A rejected command reports straight away; accepted ones report when their last beat retires.
         r_done      <= (w_accept && w_reject) || (r_p2_valid && r_p2_last);
         r_err       <= w_accept && w_reject;
         r_rsp_valid <= r_p2_valid && r_p2_read;
         if (r_p2_valid && r_p2_read) r_rsp_data <= bus.mem_dataout;

         r_p2_valid <= r_p1_valid;
         r_p2_read  <= r_p1_read;
         r_p2_last  <= r_p1_last;
         r_p1_valid <= w_issue;
         r_p1_read  <= w_issue_read;
         r_p1_last  <= w_issue && w_last_beat;

         r_mem_r_w <= w_issue_write;

         if (w_accept) begin
            r_addr       <= bus.req_addr;
            r_size       <= bus.req_size;
            r_we         <= bus.req_we;
            r_beats_left <= bus.req_len;
         end

         if (w_issue) begin
            r_mem_address     <= r_addr;
            r_mem_access_size <= r_size;
            if (w_issue_write) r_mem_datain <= bus.wr_data;
            r_addr            <= r_addr + 32'(size_bytes(r_size));
            r_beats_left      <= r_beats_left - 1'b1;
         end
      end
   end

   assign bus.req_ready       = w_req_ready;
   assign bus.wr_ready        = w_wr_ready;
   assign bus.rsp_valid       = r_rsp_valid;
   assign bus.rsp_data        = r_rsp_data;
   assign bus.done            = r_done;
   assign bus.err             = r_err;
   assign bus.mem_address     = r_mem_address;
   assign bus.mem_datain      = r_mem_datain;
   assign bus.mem_access_size = r_mem_access_size;
   assign bus.mem_r_w         = r_mem_r_w;
endmodule
`default_nettype wire

// File: tb/tb_mem_burst_initiator.sv
`default_nettype none
// ===========================================================================
// Module   : tb_mem_burst_initiator
// Purpose  : Directed and randomized bench for mem_burst_initiator against a
//            byte-level memory reference model.
// Revision : 1.0 - initial release
// ===========================================================================
module tb_mem_burst_initiator;
   localparam logic [31:0]     BASE      = 32'h8002_0000;
   localparam longint unsigned MEM_BYTES = 1048576;
   localparam longint unsigned WIN_END   = 64'h8002_0000 + MEM_BYTES;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   tests_run = 0;
   int   tests_failed = 0;

   mem_burst_initiator_if #(.LEN_BITS(4)) bus ();

   mem_burst_initiator #(
      .BASE_ADDR (BASE),
      .MEM_BYTES (1048576),
      .LEN_BITS  (4)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   // ---------------- memory device: samples at posedge, commits at negedge
   logic [7:0]  dev_mem [int unsigned];
   logic [31:0] s_addr = 32'h0;
   logic [1:0]  s_size = 2'b11;
   logic        s_rw   = 1'b0;
   logic [31:0] s_din  = 32'h0;

   function automatic logic [7:0] dev_byte(input logic [31:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
   endfunction

   always @(posedge clock) begin
      s_addr <= bus.mem_address;
      s_size <= bus.mem_access_size;
      s_rw   <= bus.mem_r_w;
      s_din  <= bus.mem_datain;
   end

   always @(negedge clock) begin
      if (s_rw) begin
         case (s_size)
            2'b11: begin
               dev_mem[s_addr]   = s_din[31:24]; dev_mem[s_addr+1] = s_din[23:16];
               dev_mem[s_addr+2] = s_din[15:8];  dev_mem[s_addr+3] = s_din[7:0];
            end
            2'b10: begin dev_mem[s_addr] = s_din[15:8]; dev_mem[s_addr+1] = s_din[7:0]; end
            default: dev_mem[s_addr] = s_din[7:0];
         endcase
      end
      case (s_size)
         2'b11:   bus.mem_dataout = {dev_byte(s_addr), dev_byte(s_addr+1), dev_byte(s_addr+2), dev_byte(s_addr+3)};
         2'b10:   bus.mem_dataout = {16'h0, dev_byte(s_addr), dev_byte(s_addr+1)};
         default: bus.mem_dataout = {24'h0, dev_byte(s_addr)};
      endcase
   end

   // ---------------- reference model: expected memory image and burst rules
   logic [7:0] ref_mem [int unsigned];

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b11) ? 4 : (s == 2'b10) ? 2 : 1;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s);
      logic [31:0] acc = 32'h0;
      for (int k = 0; k < nbytes(s); k++) begin
         logic [31:0] key = a + 32'(k);
         acc = (acc << 8) | 32'(ref_mem.exists(key) ? ref_mem[key] : 8'h00);
      end
      return acc;
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      int n = nbytes(s);
      for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = 8'(d >> (8 * (n - 1 - k)));
   endtask

   function automatic logic exp_reject(input logic [31:0] a, input logic [1:0] s, input int len);
      longint unsigned la = 64'(a);
      longint unsigned nb = 64'(nbytes(s));
      if ((la % nb) != 0) return 1'b1;
      if (la < 64'(BASE)) return 1'b1;
      return (la + 64'(len + 1) * nb) > WIN_END;
   endfunction

   // ---------------- monitor, sampled on the falling edge
   int          ncyc = 0;
   int          acc_cyc, last_wr_cyc, done_cyc, n_wr, n_rw, n_done, n_err;
   logic        done_rdy;
   logic [31:0] q_rsp [$];
   int          q_cyc [$];
   logic [31:0] exp_q [$];
   logic [31:0] wq [$];
   logic        exp_rej;

   always @(negedge clock) begin
      ncyc++;
      if (bus.req_valid && bus.req_ready && acc_cyc < 0) acc_cyc = ncyc;
      if (bus.wr_valid && bus.wr_ready) begin n_wr++; last_wr_cyc = ncyc; end
      if (bus.mem_r_w) n_rw++;
      if (bus.rsp_valid) begin q_rsp.push_back(bus.rsp_data); q_cyc.push_back(ncyc); end
      if (bus.done) begin n_done++; done_cyc = ncyc; done_rdy = bus.req_ready; end
      if (bus.err) n_err++;
   end

   // Drives one command (and its write beats) and waits for completion.
   task automatic run_burst(input logic [31:0] a, input logic [1:0] s, input logic we,
                            input int len, input int gap);
      int g, guard, nb;
      nb      = nbytes(s);
      exp_rej = exp_reject(a, s, len);
      exp_q.delete();
      if (!exp_rej && !we)
         for (int i = 0; i <= len; i++) exp_q.push_back(ref_read(a + 32'(i * nb), s));
      @(posedge clock); #1;
      acc_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
      n_wr = 0; n_rw = 0; n_done = 0; n_err = 0; done_rdy = 1'b0;
      q_rsp.delete(); q_cyc.delete();
      bus.req_valid = 1'b1; bus.req_addr = a; bus.req_size = s; bus.req_we = we; bus.req_len = 4'(len);
      guard = 0;
      do begin @(negedge clock); guard++; end while (!bus.req_ready && guard < 20);
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      if (we && !exp_rej) begin
         for (int i = 0; i <= len; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
            repeat (g) begin @(posedge clock); #1; end
            bus.wr_valid = 1'b1; bus.wr_data = wq[i];
            guard = 0;
            do begin @(negedge clock); guard++; end while (!bus.wr_ready && guard < 20);
            @(posedge clock); #1;
            bus.wr_valid = 1'b0;
            ref_write(a + 32'(i * nb), s, wq[i]);
         end
      end
      guard = 0;
      while (n_done == 0 && guard < 80) begin @(posedge clock); guard++; end
      repeat (4) @(posedge clock);
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.req_size = 2'b00; bus.req_we = 1'b0;
      bus.req_len = 4'h0; bus.wr_valid = 1'b0; bus.wr_data = 32'h0; bus.mem_dataout = 32'h0;
      reset_n = 1'b0;
      repeat (3) @(posedge clock); #1;
      tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
      tests_run++; if (bus.wr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_ready got %b want 0", bus.wr_ready); end
      tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
      tests_run++; if (bus.rsp_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
      tests_run++; if ({bus.done, bus.err} !== 2'b00) begin tests_failed++; $display("FAIL reset_done_err got %b want 00", {bus.done, bus.err}); end
      tests_run++; if (bus.mem_address !== BASE) begin tests_failed++; $display("FAIL reset_mem_address got %h want %h", bus.mem_address, BASE); end
      tests_run++; if (bus.mem_datain !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_datain got %h want 0", bus.mem_datain); end
      tests_run++; if (bus.mem_access_size !== 2'b11) begin tests_failed++; $display("FAIL reset_access_size got %b want 11", bus.mem_access_size); end
      tests_run++; if (bus.mem_r_w !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_r_w got %b want 0", bus.mem_r_w); end
      reset_n = 1'b1;
      repeat (2) @(posedge clock); #1;
      tests_run++; if (bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle got ready=%b done=%b want 1 0", bus.req_ready, bus.done); end
   endtask

   task automatic test_word_rw();
      wq = '{32'hDEAD_BEEF};
      run_burst(BASE, 2'b11, 1'b1, 0, 0);
      tests_run++; if (n_rw !== 1) begin tests_failed++; $display("FAIL word_wr_beats got %0d want 1", n_rw); end
      tests_run++; if (n_done !== 1 || n_err !== 0) begin tests_failed++; $display("FAIL word_wr_done got done=%0d err=%0d want 1 0", n_done, n_err); end
      tests_run++; if (done_cyc !== last_wr_cyc + 3) begin tests_failed++; $display("FAIL word_wr_done_time got %0d want %0d", done_cyc, last_wr_cyc + 3); end
      run_burst(BASE, 2'b11, 1'b0, 0, 0);
      tests_run++; if (q_rsp.size() !== 1) begin tests_failed++; $display("FAIL word_rd_count got %0d want 1", q_rsp.size()); end
      if (q_rsp.size() > 0) begin
         tests_run++; if (q_rsp[0] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL word_rd_data got %h want deadbeef", q_rsp[0]); end
         tests_run++; if (q_cyc[0] !== acc_cyc + 4) begin tests_failed++; $display("FAIL word_rd_latency got %0d want %0d", q_cyc[0], acc_cyc + 4); end
         tests_run++; if (done_cyc !== q_cyc[0]) begin tests_failed++; $display("FAIL word_rd_done_time got %0d want %0d", done_cyc, q_cyc[0]); end
      end
      tests_run++; if (n_err !== 0 || done_rdy !== 1'b1) begin tests_failed++; $display("FAIL word_rd_status got err=%0d ready=%b want 0 1", n_err, done_rdy); end
   endtask

   task automatic test_byte_burst();
      logic [31:0] want [4];
      want = '{32'h11, 32'h22, 32'h33, 32'h44};
      wq = '{32'h1122_3344};
      run_burst(BASE, 2'b11, 1'b1, 0, 0);
      run_burst(BASE, 2'b01, 1'b0, 3, 0);
      tests_run++; if (q_rsp.size() !== 4) begin tests_failed++; $display("FAIL byte_burst_count got %0d want 4", q_rsp.size()); end
      for (int i = 0; i < q_rsp.size() && i < 4; i++) begin
         tests_run++;
         if (q_rsp[i] !== want[i] || q_cyc[i] !== acc_cyc + 4 + i) begin
            tests_failed++;
            $display("FAIL byte_burst_beat%0d got %h@%0d want %h@%0d", i, q_rsp[i], q_cyc[i], want[i], acc_cyc + 4 + i);
         end
      end
      tests_run++; if (n_done !== 1 || done_cyc !== acc_cyc + 7) begin tests_failed++; $display("FAIL byte_burst_done got %0d@%0d want 1@%0d", n_done, done_cyc, acc_cyc + 7); end
   endtask

   task automatic test_half_gap();
      wq = '{32'h0000_AAAA, 32'h0000_BBBB};
      run_burst(BASE + 32'h10, 2'b10, 1'b1, 1, 2);
      tests_run++; if (n_rw !== 2 || n_wr !== 2) begin tests_failed++; $display("FAIL half_gap_writes got rw=%0d beats=%0d want 2 2", n_rw, n_wr); end
      tests_run++; if (n_done !== 1 || done_cyc !== last_wr_cyc + 3) begin tests_failed++; $display("FAIL half_gap_done got %0d@%0d want 1@%0d", n_done, done_cyc, last_wr_cyc + 3); end
      run_burst(BASE + 32'h10, 2'b11, 1'b0, 0, 0);
      tests_run++; if (q_rsp.size() !== 1 || q_rsp[0] !== 32'hAAAA_BBBB) begin tests_failed++; $display("FAIL half_gap_readback got n=%0d %h want 1 aaaabbbb", q_rsp.size(), (q_rsp.size() > 0) ? q_rsp[0] : 32'h0); end
   endtask

   task automatic test_reject();
      logic [31:0] ra [5];
      logic [1:0]  rs [5];
      int          rl [5];
      ra = '{32'h8002_0002, 32'h8002_0001, 32'h8011_FFFC, 32'h8001_FFFC, 32'h8002_0003};
      rs = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
      rl = '{0, 0, 1, 0, 2};
      for (int i = 0; i < 5; i++) begin
         run_burst(ra[i], rs[i], 1'(i % 2 == 0), rl[i], 0);
         tests_run++;
         if (n_err !== 1 || n_done !== 1 || n_rw !== 0 || q_rsp.size() !== 0) begin
            tests_failed++;
            $display("FAIL reject%0d got err=%0d done=%0d rw=%0d rsp=%0d want 1 1 0 0", i, n_err, n_done, n_rw, q_rsp.size());
         end
         tests_run++;
         if (done_cyc !== acc_cyc + 1 || done_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reject%0d_timing got %0d ready=%b want %0d ready=0", i, done_cyc, done_rdy, acc_cyc + 1);
         end
      end
   endtask

   task automatic test_range_edge();
      wq = '{$urandom()};
      run_burst(32'h8011_FFFC, 2'b11, 1'b1, 0, 0);
      tests_run++; if (n_err !== 0 || n_rw !== 1) begin tests_failed++; $display("FAIL edge_write got err=%0d rw=%0d want 0 1", n_err, n_rw); end
      run_burst(32'h8011_FFFC, 2'b11, 1'b0, 0, 0);
      tests_run++; if (q_rsp.size() !== 1 || q_rsp[0] !== wq[0]) begin tests_failed++; $display("FAIL edge_read got n=%0d %h want 1 %h", q_rsp.size(), (q_rsp.size() > 0) ? q_rsp[0] : 32'h0, wq[0]); end
      run_burst(32'h8011_FFFF, 2'b00, 1'b0, 0, 0);
      tests_run++; if (n_err !== 0 || q_rsp.size() !== 1 || q_rsp[0] !== {24'h0, wq[0][7:0]}) begin tests_failed++; $display("FAIL edge_last_byte got err=%0d n=%0d want 0 1", n_err, q_rsp.size()); end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [1:0]  s;
      logic        we;
      int          len, nb, exp_done, exp_rw;
      for (int it = 0; it < 40; it++) begin
         s   = 2'($urandom_range(0, 3));
         we  = 1'($urandom_range(0, 1));
         len = int'($urandom_range(0, 15));
         nb  = nbytes(s);
         case ($urandom_range(0, 3))
            0: a = BASE + 32'($urandom_range(0, 127));
            1: a = 32'(WIN_END - 64'($urandom_range(1, 72)));
            2: a = BASE - 32'($urandom_range(1, 8));
            default: a = BASE + 32'h400 + 32'($urandom_range(0, 63));
         endcase
         if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
         wq.delete();
         for (int i = 0; i <= len; i++) wq.push_back($urandom());
         run_burst(a, s, we, len, -1);
         exp_rw   = (we && !exp_rej) ? len + 1 : 0;
         exp_done = exp_rej ? acc_cyc + 1 : (we ? last_wr_cyc + 3 : acc_cyc + len + 4);
         tests_run++;
         if (n_err !== int'(exp_rej) || n_done !== 1 || n_rw !== exp_rw) begin
            tests_failed++;
            $display("FAIL rand%0d_status a=%h s=%b we=%b len=%0d got err=%0d done=%0d rw=%0d want %0d 1 %0d",
                     it, a, s, we, len, n_err, n_done, n_rw, exp_rej, exp_rw);
         end
         tests_run++; if (done_cyc !== exp_done) begin tests_failed++; $display("FAIL rand%0d_done_time got %0d want %0d", it, done_cyc, exp_done); end
         tests_run++; if (q_rsp.size() !== exp_q.size()) begin tests_failed++; $display("FAIL rand%0d_rsp_count got %0d want %0d", it, q_rsp.size(), exp_q.size()); end
         for (int i = 0; i < q_rsp.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (q_rsp[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rand%0d_rsp%0d got %h want %h", it, i, q_rsp[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_midburst();
      logic [31:0] a, d0, d1;
      a = BASE + 32'h40; d0 = $urandom(); d1 = $urandom();
      @(posedge clock); #1;
      acc_cyc = -1; n_done = 0; q_rsp.delete(); q_cyc.delete();
      bus.req_valid = 1'b1; bus.req_addr = a; bus.req_size = 2'b11; bus.req_we = 1'b1; bus.req_len = 4'd3;
      @(posedge clock); #1;
      bus.req_valid = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = d0;
      @(posedge clock); #1;
      bus.wr_data = d1;
      @(posedge clock); #2;
      tests_run++; if (bus.mem_r_w !== 1'b1 || bus.mem_address !== a + 32'h4) begin tests_failed++; $display("FAIL midburst_beat2 got rw=%b addr=%h want 1 %h", bus.mem_r_w, bus.mem_address, a + 32'h4); end
      reset_n = 1'b0; #1;
      tests_run++; if (bus.mem_r_w !== 1'b0 || bus.mem_address !== BASE) begin tests_failed++; $display("FAIL midburst_async got rw=%b addr=%h want 0 %h", bus.mem_r_w, bus.mem_address, BASE); end
      tests_run++; if (bus.req_ready !== 1'b1 || bus.wr_ready !== 1'b0) begin tests_failed++; $display("FAIL midburst_ready got req=%b wr=%b want 1 0", bus.req_ready, bus.wr_ready); end
      bus.wr_valid = 1'b0;
      repeat (2) @(posedge clock); #1;
      reset_n = 1'b1;
      repeat (6) @(posedge clock);
      tests_run++; if (n_done !== 0 || q_rsp.size() !== 0) begin tests_failed++; $display("FAIL midburst_no_done got done=%0d rsp=%0d want 0 0", n_done, q_rsp.size()); end
      // The first beat reached memory before reset; the second never did.
      ref_write(a, 2'b11, d0);
      run_burst(a, 2'b11, 1'b0, 1, 0);
      tests_run++; if (n_err !== 0 || n_done !== 1 || q_rsp.size() !== 2) begin tests_failed++; $display("FAIL midburst_reread got err=%0d done=%0d n=%0d want 0 1 2", n_err, n_done, q_rsp.size()); end
      for (int i = 0; i < q_rsp.size() && i < 2; i++) begin
         tests_run++;
         if (q_rsp[i] !== exp_q[i]) begin tests_failed++; $display("FAIL midburst_reread%0d got %h want %h", i, q_rsp[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte_burst();
      test_half_gap();
      test_reject();
      test_range_edge();
      test_random();
      test_reset_midburst();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/mem_burst_initiator.md
# mem_burst_initiator

Client-side initiator for the 1 MB byte-addressed data memory port (window 0x80020000–0x8011FFFF, big-endian, 1-cycle sampled port). It accepts burst read/write commands over a valid/ready handshake and drives the memory's address, data, access_size and r_w inputs, one beat per clock. It returns read data as a response stream and reports completion or rejection. It sits between the load/store or loader logic and the memory model.

## Interface
- BASE_ADDR, 32'h80020000, first byte address of the memory window
- MEM_BYTES, 1048576, window size in bytes
- LEN_BITS, 4, width of req_len; burst beats = req_len+1
- clock  in  1  system clock; all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid && req_ready
- req_addr  in  32  start byte address (bit 0 = MSB)
- req_size  in  2  11 word, 10 half-word, 01/00 byte
- req_we  in  1  1 write burst, 0 read burst
- req_len  in  LEN_BITS  beats minus one
- wr_valid  in  1  write beat data valid
- wr_ready  out  1  write beat data accepted
- wr_data  in  32  write data, right-justified for byte/half
- rsp_valid  out  1  read beat data valid (no backpressure)
- rsp_data  out  32  read data as returned by memory (zero-extended)
- done  out  1  one-cycle pulse: burst finished
- err  out  1  one-cycle pulse with done: command rejected, no memory access
- mem_address  out  32  to memory address
- mem_datain  out  32  to memory datain
- mem_access_size  out  2  to memory access_size
- mem_r_w  out  1  to memory r_w (1 write)
- mem_dataout  in  32  from memory dataout

## Operation
- States: IDLE, REJECT, RUN, DRAIN.
- IDLE: req_ready=1. On accept, latch addr/size/we/len; check: alignment (half: addr[31]=0; word: addr[30:31]=00) and range (addr ≥ BASE_ADDR and addr + beats·bytes ≤ BASE_ADDR+MEM_BYTES, computed in 33 bits, bytes = 1/2/4). Fail → REJECT; pass → RUN.
- REJECT: one cycle, done=1, err=1, no mem_r_w=1 ever driven; → IDLE.
- RUN read: every cycle issue one beat: register mem_address=current, mem_r_w=0, mem_access_size=latched size; address += bytes; beat counter decrements. After last beat issued → DRAIN.
- RUN write: wr_ready=1. Cycle with wr_valid: issue beat with mem_r_w=1, mem_datain=wr_data, advance. Cycle without wr_valid: issue idle beat (mem_r_w=0, address unchanged, no rsp). After last write beat issued → DRAIN.
- Outside write beats mem_r_w is always 0; idle/read cycles never modify memory.
- Completion tracked by 2-stage issue pipeline (valid, is_read, is_last); DRAIN → IDLE when last beat retires.
- Reset values: req_ready=1, wr_ready=0, rsp_valid=0, rsp_data=0, done=0, err=0, mem_address=BASE_ADDR, mem_datain=0, mem_access_size=11, mem_r_w=0, state IDLE, pipeline empty.
- Reset asserted mid-burst: all above values apply immediately (async); burst abandoned; no rsp/done for it.

## Timing
- Beat issued (registered) at posedge t; memory samples at posedge t+1; for reads mem_dataout valid after t+1, captured into rsp_data at posedge t+2, rsp_valid high for the cycle following t+2.
- Writes committed by memory at negedge after t+1.
- done high in the cycle following posedge t+2 of the last beat (reads: same cycle as last rsp_valid). State is IDLE in that cycle; req_ready=1, a new command may be accepted then.
- Accept at posedge a → first beat issued at posedge a+1. Read burst of N beats: rsp_valid at cycles after a+3 … a+N+2, done with last.
- REJECT: done/err high in the cycle after accept posedge+1; req_ready=0 during it.
- Address advance wraps never: range check guarantees no overflow.

## Test plan
- Word write 0x80020000 ← 0xDEADBEEF (len 0), then word read same → rsp_data=0xDEADBEEF, exactly one rsp_valid, done with it, err=0.
- Byte read burst addr 0x80020000, len 3, after prior word write 0x11223344 → rsp_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, done on the 4th.
- Half-word write burst addr 0x80020010, len 1, data 0xAAAA then 0xBBBB with wr_valid low 2 cycles between → mem_r_w=1 on exactly 2 cycles; word read 0x80020010 → 0xAAAABBBB.
- Misaligned word 0x80020002 and half 0x80020001 → done+err pulse, mem_r_w never 1, no rsp_valid.
- Range: word read 0x8011FFFC len 0 → accepted, completes; len 1 → err; addr 0x8001FFFC → err.
- reset_n low during beat 2 of 4-beat write → mem_r_w=0 immediately, no done; after release req_ready=1 and new read succeeds.
